// File: rtl/ps2_key_tracker_if.sv
// Bundles the PS/2 wire pair and the decoded key-tracking outputs of
// ps2_key_tracker so the tracker and its consumer share one port.
interface ps2_key_tracker_if #(
   parameter int NUM_KEYS = 4
);
   localparam int CW = $clog2(NUM_KEYS + 1);

   logic          PS2Clk;
   logic          PS2Data;
   logic [7:0]    scancode;
   logic          extended;
   logic          keyPressed;
   logic [CW-1:0] keyCount;
   logic          keyEvent;
   logic          eventBreak;
   logic          parityErr;
   logic          overflow;

   // Keyboard / stimulus side: drives the PS/2 wires, observes key state
   modport master (
      output PS2Clk, PS2Data,
      input  scancode, extended, keyPressed, keyCount,
      input  keyEvent, eventBreak, parityErr, overflow
   );

   // Tracker side: receives the PS/2 wires, reports key state
   modport slave (
      input  PS2Clk, PS2Data,
      output scancode, extended, keyPressed, keyCount,
      output keyEvent, eventBreak, parityErr, overflow
   );
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver that decodes set-2 make/break/E0 sequences and
// keeps a small table of currently held keys (9-bit {ext, code} entries).
module ps2_key_tracker #(
   parameter int NUM_KEYS       = 4,
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int SYNC_STAGES    = 2
) (
   input logic clk,
   input logic rst,
   ps2_key_tracker_if.slave bus
);
   localparam int CW = $clog2(NUM_KEYS + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
   logic                   clk_prev_q, clk_prev_d;
   frame_state_t           state_q, state_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             shift_q, shift_d;
   logic                   parity_q, parity_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic                   rx_done_q, rx_done_d;
   logic [7:0]             rx_byte_q, rx_byte_d;
   logic                   rx_par_ok_q, rx_par_ok_d;
   logic                   rx_stop_q, rx_stop_d;
   logic                   ext_q, ext_d, brk_q, brk_d;
   logic [NUM_KEYS-1:0]    slot_valid_q, slot_valid_d;
   logic [NUM_KEYS-1:0][8:0] slot_key_q, slot_key_d;
   logic [CW-1:0]          count_q, count_d;
   logic [7:0]             scancode_q, scancode_d;
   logic                   extended_q, extended_d;
   logic                   event_q, event_d, event_break_q, event_break_d;
   logic                   perr_q, perr_d, ovf_q, ovf_d;

   logic                   ps2_clk_s, ps2_data_s, ps2_fall;
   logic [8:0]             key;
   logic                   hit, free;
   logic [IW-1:0]          hit_idx, free_idx;

   assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
   assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
   assign ps2_fall   = clk_prev_q & ~ps2_clk_s;
   assign key        = {ext_q, rx_byte_q};

   // Shift the asynchronous PS/2 wires into the clk domain and remember the last clock level
   always_comb begin
      clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], bus.PS2Clk};
      data_sync_d = {data_sync_q[SYNC_STAGES-2:0], bus.PS2Data};
      clk_prev_d  = ps2_clk_s;
   end

   // Frame FSM: one bit per falling edge, abandoning a stalled frame after the timeout
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      parity_d    = parity_q;
      timer_d     = timer_q;
      rx_done_d   = 1'b0;
      rx_byte_d   = rx_byte_q;
      rx_par_ok_d = rx_par_ok_q;
      rx_stop_d   = rx_stop_q;
      if (ps2_fall) begin
         timer_d = '0;
         case (state_q)
            IDLE: begin
               if (!ps2_data_s) begin
                  state_d   = DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            DATA: begin
               shift_d   = {ps2_data_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               parity_d = ps2_data_s;
               state_d  = STOP;
            end
            default: begin
               state_d     = IDLE;
               rx_done_d   = 1'b1;
               rx_byte_d   = shift_q;
               rx_par_ok_d = ^{shift_q, parity_q};
               rx_stop_d   = ps2_data_s;
            end
         endcase
      end else if (state_q != IDLE) begin
         if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            timer_d = '0;
         end else begin
            timer_d = timer_q + TW'(1);
         end
      end
   end

   // Locate the received key in the table and the lowest empty slot
   always_comb begin
      hit      = 1'b0;
      free     = 1'b0;
      hit_idx  = '0;
      free_idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (slot_valid_q[i[IW-1:0]] && (slot_key_q[i[IW-1:0]] == key)) begin
            hit     = 1'b1;
            hit_idx = i[IW-1:0];
         end
         if (!slot_valid_q[i[IW-1:0]]) begin
            free     = 1'b1;
            free_idx = i[IW-1:0];
         end
      end
   end

   // Byte decoder: prefix flags, then at most one table insert or remove per byte
   always_comb begin
      ext_d         = ext_q;
      brk_d         = brk_q;
      slot_valid_d  = slot_valid_q;
      slot_key_d    = slot_key_q;
      count_d       = count_q;
      scancode_d    = scancode_q;
      extended_d    = extended_q;
      event_d       = 1'b0;
      event_break_d = event_break_q;
      perr_d        = 1'b0;
      ovf_d         = 1'b0;
      if (rx_done_q && rx_stop_q) begin
         if (!rx_par_ok_q) begin
            perr_d = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
         end else if (rx_byte_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (rx_byte_q == 8'hF0) begin
            brk_d = 1'b1;
         end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (brk_q) begin
               if (hit) begin
                  slot_valid_d[hit_idx] = 1'b0;
                  count_d               = count_q - CW'(1);
                  event_d               = 1'b1;
                  event_break_d         = 1'b1;
               end
            end else if (!hit) begin
               if (free) begin
                  slot_valid_d[free_idx] = 1'b1;
                  slot_key_d[free_idx]   = key;
                  count_d                = count_q + CW'(1);
                  scancode_d             = rx_byte_q;
                  extended_d             = ext_q;
                  event_d                = 1'b1;
                  event_break_d          = 1'b0;
               end else begin
                  ovf_d = 1'b1;
               end
            end
         end
      end
   end

   // State register for synchronisers, frame FSM, decoder and key table
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync_q    <= '1;
         data_sync_q   <= '1;
         clk_prev_q    <= 1'b1;
         state_q       <= IDLE;
         bit_cnt_q     <= 3'd0;
         shift_q       <= 8'h00;
         parity_q      <= 1'b0;
         timer_q       <= '0;
         rx_done_q     <= 1'b0;
         rx_byte_q     <= 8'h00;
         rx_par_ok_q   <= 1'b0;
         rx_stop_q     <= 1'b0;
         ext_q         <= 1'b0;
         brk_q         <= 1'b0;
         slot_valid_q  <= '0;
         slot_key_q    <= '0;
         count_q       <= '0;
         scancode_q    <= 8'h00;
         extended_q    <= 1'b0;
         event_q       <= 1'b0;
         event_break_q <= 1'b0;
         perr_q        <= 1'b0;
         ovf_q         <= 1'b0;
      end else begin
         clk_sync_q    <= clk_sync_d;
         data_sync_q   <= data_sync_d;
         clk_prev_q    <= clk_prev_d;
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         parity_q      <= parity_d;
         timer_q       <= timer_d;
         rx_done_q     <= rx_done_d;
         rx_byte_q     <= rx_byte_d;
         rx_par_ok_q   <= rx_par_ok_d;
         rx_stop_q     <= rx_stop_d;
         ext_q         <= ext_d;
         brk_q         <= brk_d;
         slot_valid_q  <= slot_valid_d;
         slot_key_q    <= slot_key_d;
         count_q       <= count_d;
         scancode_q    <= scancode_d;
         extended_q    <= extended_d;
         event_q       <= event_d;
         event_break_q <= event_break_d;
         perr_q        <= perr_d;
         ovf_q         <= ovf_d;
      end
   end

   assign bus.scancode   = scancode_q;
   assign bus.extended   = extended_q;
   assign bus.keyCount   = count_q;
   assign bus.keyPressed = (count_q != '0);
   assign bus.keyEvent   = event_q;
   assign bus.eventBreak = event_break_q;
   assign bus.parityErr  = perr_q;
   assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed scenarios followed by
// randomized key traffic, all compared against a queue-based key model.
module tb_ps2_key_tracker;
   localparam int NK   = 4;
   localparam int TO   = 200;
   localparam int SS   = 2;
   localparam int HALF = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ps2_key_tracker_if #(.NUM_KEYS(NK)) bus ();

   ps2_key_tracker #(.NUM_KEYS(NK), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(SS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int stop_cyc = 0;
   int last_pulse_cyc = 0;
   int ins_cnt = 0, rem_cnt = 0, ovf_cnt = 0, perr_cnt = 0;

   logic [8:0] held[$];
   bit         m_ext, m_brk, m_ex;
   logic [7:0] m_sc;
   int         exp_ins, exp_rem, exp_ovf, exp_perr;
   logic [7:0] pool [8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h11, 8'h75, 8'h7D};

   // Free-running cycle counter used to time output pulses
   always @(posedge clk) cyc <= cyc + 1;

   // Count every output pulse observed away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.keyEvent) begin
            if (bus.eventBreak) rem_cnt++;
            else ins_cnt++;
            last_pulse_cyc = cyc;
         end
         if (bus.overflow) begin
            ovf_cnt++;
            last_pulse_cyc = cyc;
         end
         if (bus.parityErr) begin
            perr_cnt++;
            last_pulse_cyc = cyc;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive the first n_edges bits of a PS/2 frame; clock is left high afterwards
   task automatic applyStimulus(input logic [7:0] code, input bit flip_parity, input bit stop_bit, input int n_edges);
      logic [10:0] frame;
      frame = {stop_bit, (~^code) ^ flip_parity, code, 1'b0};
      for (int e = 0; e < n_edges; e++) begin
         bus.PS2Data = frame[e];
         waitCycles(HALF);
         bus.PS2Clk = 1'b0;
         if (e == 10) stop_cyc = cyc;
         waitCycles(HALF);
         bus.PS2Clk = 1'b1;
      end
      bus.PS2Data = 1'b1;
      waitCycles(HALF);
   endtask

   // Reference behaviour of one complete received byte
   task automatic modelByte(input logic [7:0] code, input bit par_ok, input bit stop_ok);
      logic [8:0] k;
      int idx;
      exp_ins = 0; exp_rem = 0; exp_ovf = 0; exp_perr = 0;
      if (!stop_ok) return;
      if (!par_ok) begin
         exp_perr = 1; m_ext = 0; m_brk = 0;
         return;
      end
      if (code == 8'hE0) begin m_ext = 1; return; end
      if (code == 8'hF0) begin m_brk = 1; return; end
      k = {m_ext, code};
      idx = -1;
      foreach (held[i]) if (held[i] == k) idx = i;
      if (m_brk) begin
         if (idx >= 0) begin held.delete(idx); exp_rem = 1; end
      end else if (idx < 0) begin
         if (held.size() == NK) exp_ovf = 1;
         else begin held.push_back(k); exp_ins = 1; m_sc = code; m_ex = m_ext; end
      end
      m_ext = 0; m_brk = 0;
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, " keyCount"}, 32'(bus.keyCount), held.size());
      checkOutput({tag, " keyPressed"}, 32'(bus.keyPressed), 32'(held.size() != 0));
      checkOutput({tag, " scancode"}, 32'(bus.scancode), 32'(m_sc));
      checkOutput({tag, " extended"}, 32'(bus.extended), 32'(m_ex));
   endtask

   task automatic sendFrame(input logic [7:0] code, input bit flip, input bit stop_bit);
      int i0, r0, o0, p0;
      string tag;
      i0 = ins_cnt; r0 = rem_cnt; o0 = ovf_cnt; p0 = perr_cnt;
      tag = $sformatf("byte %02h", code);
      applyStimulus(code, flip, stop_bit, 11);
      modelByte(code, !flip, stop_bit);
      waitCycles(4);
      checkOutput({tag, " inserts"}, ins_cnt - i0, exp_ins);
      checkOutput({tag, " removes"}, rem_cnt - r0, exp_rem);
      checkOutput({tag, " overflow"}, ovf_cnt - o0, exp_ovf);
      checkOutput({tag, " parityErr"}, perr_cnt - p0, exp_perr);
      if (exp_ins + exp_rem + exp_ovf + exp_perr != 0)
         checkOutput({tag, " latency"}, last_pulse_cyc - stop_cyc, SS + 2);
      checkState(tag);
   endtask

   task automatic partialTimeout(input logic [7:0] code, input int n_edges);
      int total0;
      total0 = ins_cnt + rem_cnt + ovf_cnt + perr_cnt;
      applyStimulus(code, 1'b0, 1'b1, n_edges);
      waitCycles(TO + 50);
      checkOutput("partial pulses", ins_cnt + rem_cnt + ovf_cnt + perr_cnt - total0, 0);
      checkState("partial");
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
      $fatal(1);
   end

   initial begin
      logic [8:0] k;
      bit         brk;
      rst = 1'b1;
      bus.PS2Clk = 1'b1;
      bus.PS2Data = 1'b1;
      m_ext = 0; m_brk = 0; m_ex = 0; m_sc = 8'h00;
      waitCycles(5);
      checkState("reset");
      checkOutput("reset keyEvent", 32'(bus.keyEvent), 0);
      checkOutput("reset eventBreak", 32'(bus.eventBreak), 0);
      rst = 1'b0;
      waitCycles(5);

      // Single key press and release
      sendFrame(8'h7D, 0, 1);
      sendFrame(8'hF0, 0, 1);
      sendFrame(8'h7D, 0, 1);
      // Typematic repeats
      sendFrame(8'h75, 0, 1);
      sendFrame(8'h75, 0, 1);
      sendFrame(8'h75, 0, 1);
      sendFrame(8'hF0, 0, 1);
      sendFrame(8'h75, 0, 1);
      // Extended and plain versions of the same code are distinct
      sendFrame(8'hE0, 0, 1);
      sendFrame(8'h11, 0, 1);
      sendFrame(8'h11, 0, 1);
      sendFrame(8'hE0, 0, 1);
      sendFrame(8'hF0, 0, 1);
      sendFrame(8'h11, 0, 1);
      sendFrame(8'hF0, 0, 1);
      sendFrame(8'h11, 0, 1);
      // Fill the table and overflow it
      sendFrame(8'h1C, 0, 1);
      sendFrame(8'h1B, 0, 1);
      sendFrame(8'h23, 0, 1);
      sendFrame(8'h2B, 0, 1);
      sendFrame(8'h34, 0, 1);
      foreach (pool[i]) begin
         if (i < 4) begin
            sendFrame(8'hF0, 0, 1);
            sendFrame(pool[i], 0, 1);
         end
      end
      // Parity error then valid frame, and a bad stop bit
      sendFrame(8'h7D, 1, 1);
      sendFrame(8'h7D, 0, 1);
      sendFrame(8'h23, 0, 0);
      // Stalled partial frame followed by a valid one
      partialTimeout(8'h5A, 5);
      sendFrame(8'h75, 0, 1);
      // Reset in the middle of a frame
      applyStimulus(8'h55, 0, 1, 5);
      rst = 1'b1;
      waitCycles(3);
      held.delete();
      m_ext = 0; m_brk = 0; m_sc = 8'h00; m_ex = 0;
      checkState("midframe reset");
      checkOutput("midframe reset eventBreak", 32'(bus.eventBreak), 0);
      rst = 1'b0;
      waitCycles(5);
      sendFrame(8'h1C, 0, 1);

      // Randomized key traffic with occasional corrupt and stalled frames
      for (int it = 0; it < 90; it++) begin
         if ($urandom_range(0, 29) == 0) begin
            partialTimeout(8'($urandom), $urandom_range(1, 10));
         end else begin
            brk = (held.size() > 0) && ($urandom_range(0, 1) == 1);
            if (brk && $urandom_range(0, 3) != 0)
               k = held[$urandom_range(0, held.size() - 1)];
            else
               k = {($urandom_range(0, 3) == 0), pool[$urandom_range(0, 7)]};
            if (k[8]) sendFrame(8'hE0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 24) != 0));
            if (brk) sendFrame(8'hF0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 24) != 0));
            sendFrame(k[7:0], ($urandom_range(0, 19) == 0), ($urandom_range(0, 24) != 0));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
